// File: rtl/stack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stack_pkg : shared FSM encoding and entry-width constants for position_stack
// Revision  : 1.0
// ---------------------------------------------------------------------------
package stack_pkg;

  localparam int unsigned C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    DEC   = 3'd2,
    READ  = 3'd3,
    ACK   = 3'd4
  } state_e;

  localparam int unsigned C_ROW_W   = 3;
  localparam int unsigned C_COL_W   = 3;
  localparam int unsigned C_ENTRY_W = C_ROW_W + C_COL_W;

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stack_mem : DEPTH x WIDTH RAM, sync write, registered read port(s)
//             (second read port when STACK_PEEK_EN is defined)
// Revision  : 1.0
// ---------------------------------------------------------------------------
module stack_mem
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = C_ENTRY_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
`ifdef STACK_PEEK_EN
  input  logic             pk_en,
  input  logic [AW-1:0]    pk_addr,
  output logic [WIDTH-1:0] pk_data,
`endif
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

`ifdef STACK_PEEK_EN
  logic [WIDTH-1:0] pk_data_q, pk_data_d;

  always_comb begin
    pk_data_d = pk_en ? mem_q[pk_addr] : pk_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pk_data_q <= '0;
    end else begin
      pk_data_q <= pk_data_d;
    end
  end

  assign pk_data = pk_data_q;
`endif

endmodule
`default_nettype wire

// File: rtl/position_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// position_stack : LIFO of (row, column) queen positions with ack handshake
//                  and sticky under/overflow; STACK_PEEK_EN adds top_data/top_valid
// Revision       : 1.0
// ---------------------------------------------------------------------------
module position_stack
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROW_W = C_ROW_W,
  parameter int unsigned COL_W = C_COL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ROW_W+COL_W-1:0]   push_data,
  output logic [ROW_W+COL_W-1:0]   pop_data,
  output logic                     stack_ready,
  output logic                     underflow,
  output logic                     overflow,
`ifdef STACK_PEEK_EN
  output logic [ROW_W+COL_W-1:0]   top_data,
  output logic                     top_valid,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned c_entry_w = ROW_W + COL_W;
  localparam int unsigned c_aw      = $clog2(DEPTH);
  localparam int unsigned c_lvl_w   = c_aw + 1;
  localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

  state_e               state_q, state_d;
  logic [c_lvl_w-1:0]   level_q, level_d;
  logic [c_entry_w-1:0] data_q, data_d;
  logic                 underflow_q, underflow_d;
  logic                 overflow_q, overflow_d;
  logic                 stack_ready_q, stack_ready_d;
  logic                 mem_we, mem_re;
  logic                 wr_en;
  logic                 full, empty;

  assign full  = (level_q == c_full);
  assign empty = (level_q == '0);

`ifdef STACK_PEEK_EN
  logic            peek_re;
  logic            top_valid_q, top_valid_d;
  logic [c_aw-1:0] peek_addr;

  assign peek_addr = level_q[c_aw-1:0] - 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    data_d        = data_q;
    underflow_d   = underflow_q;
    overflow_d    = overflow_q;
    stack_ready_d = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
`ifdef STACK_PEEK_EN
    peek_re       = 1'b0;
    top_valid_d   = top_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = DEC;
        end else if (push) begin
          state_d = WRITE;
          data_d  = push_data;
        end
      end
      WRITE: begin
        if (!full) begin
          mem_we      = 1'b1;
          level_d     = level_q + 1'b1;
          underflow_d = 1'b0;
        end else begin
          overflow_d  = 1'b1;
        end
        state_d       = ACK;
        stack_ready_d = 1'b1;
      end
      DEC: begin
        if (!empty) begin
          level_d    = level_q - 1'b1;
          overflow_d = 1'b0;
          state_d    = READ;
        end else begin
          // Empty pop skips READ so pop_data keeps the last good entry.
          underflow_d   = 1'b1;
          state_d       = ACK;
          stack_ready_d = 1'b1;
        end
      end
      READ: begin
        mem_re        = 1'b1;
        state_d       = ACK;
        stack_ready_d = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
`ifdef STACK_PEEK_EN
        peek_re     = 1'b1;
        top_valid_d = !empty;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      level_q       <= '0;
      data_q        <= '0;
      underflow_q   <= 1'b0;
      overflow_q    <= 1'b0;
      stack_ready_q <= 1'b0;
`ifdef STACK_PEEK_EN
      top_valid_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      data_q        <= data_d;
      underflow_q   <= underflow_d;
      overflow_q    <= overflow_d;
      stack_ready_q <= stack_ready_d;
`ifdef STACK_PEEK_EN
      top_valid_q   <= top_valid_d;
`endif
    end
  end

  // A write coinciding with reset must not land in the unreset storage.
  assign wr_en = mem_we & ~reset;

  stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w),
    .AW    (c_aw)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (level_q[c_aw-1:0]),
    .wr_data (data_q),
    .rd_en   (mem_re),
    .rd_addr (level_q[c_aw-1:0]),
`ifdef STACK_PEEK_EN
    .pk_en   (peek_re),
    .pk_addr (peek_addr),
    .pk_data (top_data),
`endif
    .rd_data (pop_data)
  );

  assign stack_ready = stack_ready_q;
  assign underflow   = underflow_q;
  assign overflow    = overflow_q;
  assign level       = level_q;
`ifdef STACK_PEEK_EN
  assign top_valid   = top_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_position_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_position_stack : directed self-checking bench for position_stack
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_position_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [5:0] push_data = '0;
  logic [5:0] pop_data;
  logic       stack_ready;
  logic       underflow;
  logic       overflow;
  logic [3:0] level;
`ifdef STACK_PEEK_EN
  logic [5:0] top_data;
  logic       top_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  position_stack #(.DEPTH(8), .ROW_W(3), .COL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_data   (push_data),
    .pop_data    (pop_data),
    .stack_ready (stack_ready),
    .underflow   (underflow),
    .overflow    (overflow),
`ifdef STACK_PEEK_EN
    .top_data    (top_data),
    .top_valid   (top_valid),
`endif
    .level       (level)
  );

  task automatic apply_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one request from IDLE, return edges-to-ack (accept edge = 1) and
  // the outputs seen in the ack cycle; finishes one cycle later, back in IDLE.
  task automatic do_req(input logic p_push, input logic p_pop, input logic [5:0] d,
                        output int lat, output logic [5:0] pd, output logic [3:0] lv,
                        output logic uf, output logic of, output logic rdy_after);
    push = p_push; pop = p_pop; push_data = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    lat = 1;
    while (!stack_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    pd = pop_data; lv = level; uf = underflow; of = overflow;
    @(posedge clk); #1;
    rdy_after = stack_ready;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (pop_data !== 6'o00) begin n_err++; $display("FAIL reset_pop_data: got %h expected %h", pop_data, 6'o00); end
    n_cmp++; if (stack_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", stack_ready); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
  endtask

  task automatic test_push_single();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    do_req(1'b1, 1'b0, 6'o05, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL push_latency: got %0d expected 2", lat); end
    n_cmp++; if (lv !== 4'd1) begin n_err++; $display("FAIL push_level: got %0d expected 1", lv); end
    n_cmp++; if (ra !== 1'b0) begin n_err++; $display("FAIL push_ready_width: got %b expected 0", ra); end
  endtask

  task automatic test_push_pop();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    do_req(1'b1, 1'b0, 6'o12, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lv !== 4'd2) begin n_err++; $display("FAIL push2_level: got %0d expected 2", lv); end
    do_req(1'b0, 1'b1, 6'o00, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL pop_latency: got %0d expected 3", lat); end
    n_cmp++; if (pd !== 6'o12) begin n_err++; $display("FAIL pop1_data: got %h expected %h", pd, 6'o12); end
    n_cmp++; if (lv !== 4'd1) begin n_err++; $display("FAIL pop1_level: got %0d expected 1", lv); end
    n_cmp++; if (ra !== 1'b0) begin n_err++; $display("FAIL pop_ready_width: got %b expected 0", ra); end
    do_req(1'b0, 1'b1, 6'o00, lat, pd, lv, uf, of, ra);
    n_cmp++; if (pd !== 6'o05) begin n_err++; $display("FAIL pop2_data: got %h expected %h", pd, 6'o05); end
    n_cmp++; if (lv !== 4'd0) begin n_err++; $display("FAIL pop2_level: got %0d expected 0", lv); end
  endtask

  task automatic test_empty_pop();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    do_req(1'b0, 1'b1, 6'o00, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL empty_pop_latency: got %0d expected 2", lat); end
    n_cmp++; if (uf !== 1'b1) begin n_err++; $display("FAIL empty_pop_underflow: got %b expected 1", uf); end
    n_cmp++; if (pd !== 6'o05) begin n_err++; $display("FAIL empty_pop_data_held: got %h expected %h", pd, 6'o05); end
    n_cmp++; if (lv !== 4'd0) begin n_err++; $display("FAIL empty_pop_level: got %0d expected 0", lv); end
    do_req(1'b1, 1'b0, 6'o27, lat, pd, lv, uf, of, ra);
    n_cmp++; if (uf !== 1'b0) begin n_err++; $display("FAIL push_clears_underflow: got %b expected 0", uf); end
    n_cmp++; if (lv !== 4'd1) begin n_err++; $display("FAIL push_after_empty_level: got %0d expected 1", lv); end
  endtask

  task automatic test_overflow();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    logic [2:0] r;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      r = 3'(i);
      do_req(1'b1, 1'b0, {r, ~r}, lat, pd, lv, uf, of, ra);
    end
    n_cmp++; if (of !== 1'b0) begin n_err++; $display("FAIL full_no_overflow: got %b expected 0", of); end
    do_req(1'b1, 1'b0, 6'o44, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL overflow_latency: got %0d expected 2", lat); end
    n_cmp++; if (of !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b expected 1", of); end
    n_cmp++; if (lv !== 4'd8) begin n_err++; $display("FAIL overflow_level: got %0d expected 8", lv); end
    do_req(1'b0, 1'b1, 6'o00, lat, pd, lv, uf, of, ra);
    n_cmp++; if (pd !== 6'o70) begin n_err++; $display("FAIL overflow_pop_data: got %h expected %h", pd, 6'o70); end
    n_cmp++; if (of !== 1'b0) begin n_err++; $display("FAIL pop_clears_overflow: got %b expected 0", of); end
    n_cmp++; if (lv !== 4'd7) begin n_err++; $display("FAIL overflow_pop_level: got %0d expected 7", lv); end
  endtask

  task automatic test_push_pop_together();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    apply_reset();
    do_req(1'b1, 1'b0, 6'o11, lat, pd, lv, uf, of, ra);
    do_req(1'b1, 1'b0, 6'o22, lat, pd, lv, uf, of, ra);
    do_req(1'b1, 1'b1, 6'o33, lat, pd, lv, uf, of, ra);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL both_latency: got %0d expected 3", lat); end
    n_cmp++; if (pd !== 6'o22) begin n_err++; $display("FAIL both_pop_data: got %h expected %h", pd, 6'o22); end
    n_cmp++; if (lv !== 4'd1) begin n_err++; $display("FAIL both_level: got %0d expected 1", lv); end
    do_req(1'b0, 1'b1, 6'o00, lat, pd, lv, uf, of, ra);
    n_cmp++; if (pd !== 6'o11) begin n_err++; $display("FAIL both_no_push_data: got %h expected %h", pd, 6'o11); end
  endtask

  task automatic test_held_pop();
    int lat; logic [5:0] pd; logic [3:0] lv; logic uf, of, ra;
    int gap;
    logic [5:0] exp_pd [4];
    logic [3:0] exp_lv [4];
    int         exp_gap [4];
    exp_pd  = '{6'o03, 6'o02, 6'o01, 6'o01};
    exp_lv  = '{4'd2, 4'd1, 4'd0, 4'd0};
    exp_gap = '{3, 4, 4, 3};
    apply_reset();
    do_req(1'b1, 1'b0, 6'o01, lat, pd, lv, uf, of, ra);
    do_req(1'b1, 1'b0, 6'o02, lat, pd, lv, uf, of, ra);
    do_req(1'b1, 1'b0, 6'o03, lat, pd, lv, uf, of, ra);
    pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        @(posedge clk); #1;
        gap++;
      end while (!stack_ready && gap < 12);
      if (k == 3) pop = 1'b0;
      n_cmp++; if (gap !== exp_gap[k]) begin n_err++; $display("FAIL held_gap[%0d]: got %0d expected %0d", k, gap, exp_gap[k]); end
      n_cmp++; if (pop_data !== exp_pd[k]) begin n_err++; $display("FAIL held_data[%0d]: got %h expected %h", k, pop_data, exp_pd[k]); end
      n_cmp++; if (level !== exp_lv[k]) begin n_err++; $display("FAIL held_level[%0d]: got %0d expected %0d", k, level, exp_lv[k]); end
      n_cmp++; if (underflow !== (k == 3)) begin n_err++; $display("FAIL held_underflow[%0d]: got %b expected %b", k, underflow, (k == 3)); end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stack_ready !== 1'b0) begin n_err++; $display("FAIL held_released: got %b expected 0", stack_ready); end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    push = 1'b1; push_data = 6'o56;
    @(posedge clk); #1;
    push = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL midwrite_level: got %0d expected 0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL midwrite_underflow: got %b expected 0", underflow); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (stack_ready) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midwrite_no_ack: got %0d pulses expected 0", seen); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL midwrite_level_after: got %0d expected 0", level); end
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_push_pop();
    test_empty_pop();
    test_overflow();
    test_push_pop_together();
    test_held_pop();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
